// File: rtl/cop0_timer_regs_if.sv
// COP0 register-file bus: mfc0/mtc0 access, eret/exception signalling,
// interrupt lines and status outputs.
// The optional COP0_BADVADDR_EN macro adds the iBadVAddr input.
interface cop0_timer_regs_if #(
    parameter int NUM_CMP = 2
);
    logic [4:0]         iReadRegister;
    logic [4:0]         iWriteRegister;
    logic [31:0]        iWriteData;
    logic               iRegWrite;
    logic [31:0]        oReadData;
    logic               iEret;
    logic               iExcOccurred;
    logic               iBranchDelay;
    logic [31:0]        iExcEPC;
    logic [4:0]         iExcCode;
    logic [6:0]         iPendingInterrupt;
    logic [7:0]         oInterruptMask;
    logic               oIrq;
    logic               oUserMode;
    logic               oExcLevel;
    logic [NUM_CMP-1:0] oTimerPending;
`ifdef COP0_BADVADDR_EN
    logic [31:0]        iBadVAddr;
`endif

    modport master (
        output iReadRegister, iWriteRegister, iWriteData, iRegWrite,
        output iEret, iExcOccurred, iBranchDelay, iExcEPC, iExcCode,
        output iPendingInterrupt,
`ifdef COP0_BADVADDR_EN
        output iBadVAddr,
`endif
        input  oReadData, oInterruptMask, oIrq, oUserMode, oExcLevel,
        input  oTimerPending
    );

    modport slave (
        input  iReadRegister, iWriteRegister, iWriteData, iRegWrite,
        input  iEret, iExcOccurred, iBranchDelay, iExcEPC, iExcCode,
        input  iPendingInterrupt,
`ifdef COP0_BADVADDR_EN
        input  iBadVAddr,
`endif
        output oReadData, oInterruptMask, oIrq, oUserMode, oExcLevel,
        output oTimerPending
    );
endinterface

// File: rtl/cop0_timer_regs.sv
// COP0 register file with prescaled Count, NUM_CMP compare channels with
// sticky pending bits, SR, Cause and EPC.
// Optional macro COP0_BADVADDR_EN adds the read-only BadVAddr register ($8).
module cop0_timer_regs #(
    parameter int          NUM_CMP  = 2,
    parameter int          PRESCALE = 2,
    parameter logic [31:0] SR_RESET = 32'h00000511
) (
    input  logic              iCLK,
    input  logic              iCLR,
    cop0_timer_regs_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]      preCnt_r;
    logic [31:0]        count_r;
    logic [31:0]        compare_r [NUM_CMP];
    logic [NUM_CMP-1:0] tp_r;
    logic [31:0]        sr_r;
    logic [31:0]        epc_r;
    logic               causeBd_r;
    logic [4:0]         excCode_r;
    logic [1:0]         swInt_r;
`ifdef COP0_BADVADDR_EN
    logic [31:0]        badVAddr_r;
`endif

    logic               tick_s;
    logic               excAct_s;
    logic               wrAct_s;
    logic               wrCount_s;
    logic               wrSr_s;
    logic               wrCause_s;
    logic [NUM_CMP-1:0] wrCmp_s;
    logic [31:0]        cmpRead_s;
    logic [31:0]        causeRead_s;
    logic [31:0]        readData_s;
    logic [7:0]         mask_s;

    // Register number of compare channel k: Compare0 is $11, the rest follow $21.
    function automatic logic [4:0] cmpAddr(input int k);
        if (k == 0) cmpAddr = 5'd11;
        else        cmpAddr = 5'(21 + k);
    endfunction

    // Arbitration (eret > exception > mtc0) and mtc0 address decode.
    always_comb begin
        tick_s    = (preCnt_r == PW'(PRESCALE - 1));
        excAct_s  = bus.iExcOccurred & ~bus.iEret;
        wrAct_s   = bus.iRegWrite & ~bus.iEret & ~bus.iExcOccurred;
        wrCount_s = wrAct_s && (bus.iWriteRegister == 5'd9);
        wrSr_s    = wrAct_s && (bus.iWriteRegister == 5'd12);
        wrCause_s = wrAct_s && (bus.iWriteRegister == 5'd13);
        wrCmp_s   = '0;
        for (int k = 0; k < NUM_CMP; k++) begin
            wrCmp_s[k] = wrAct_s && (bus.iWriteRegister == cmpAddr(k));
        end
    end

    // Prescaler: counts 0..PRESCALE-1; reset discards any partial count.
    always_ff @(posedge iCLK) begin
        if (iCLR)        preCnt_r <= '0;
        else if (tick_s) preCnt_r <= '0;
        else             preCnt_r <= preCnt_r + PW'(1);
    end

    // Count: an mtc0 load takes the place of that cycle's increment.
    always_ff @(posedge iCLK) begin
        if (iCLR)           count_r <= 32'd0;
        else if (wrCount_s) count_r <= bus.iWriteData;
        else if (tick_s)    count_r <= count_r + 32'd1;
    end

    // Compare registers and sticky match flags; a compare write beats a match.
    always_ff @(posedge iCLK) begin
        for (int k = 0; k < NUM_CMP; k++) begin
            if (iCLR) begin
                compare_r[k] <= 32'd0;
                tp_r[k]      <= 1'b0;
            end else if (wrCmp_s[k]) begin
                compare_r[k] <= bus.iWriteData;
                tp_r[k]      <= 1'b0;
            end else if (tick_s && (count_r == compare_r[k])) begin
                tp_r[k]      <= 1'b1;
            end
        end
    end

    // Status register: eret/exception flip UM (bit 4) and EL (bit 1).
    always_ff @(posedge iCLK) begin
        if (iCLR)                  sr_r <= SR_RESET;
        else if (bus.iEret)        sr_r <= {sr_r[31:5], 1'b1, sr_r[3:2], 1'b0, sr_r[0]};
        else if (bus.iExcOccurred) sr_r <= {sr_r[31:5], 1'b0, sr_r[3:2], 1'b1, sr_r[0]};
        else if (wrSr_s)           sr_r <= bus.iWriteData;
    end

    // Cause/EPC: exception capture, software-interrupt bits via mtc0.
    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            causeBd_r <= 1'b0;
            excCode_r <= 5'd0;
            swInt_r   <= 2'd0;
            epc_r     <= 32'd0;
        end else if (excAct_s) begin
            causeBd_r <= bus.iBranchDelay;
            excCode_r <= bus.iExcCode;
            epc_r     <= bus.iExcEPC;
        end else if (wrCause_s) begin
            swInt_r   <= bus.iWriteData[9:8];
        end
    end

`ifdef COP0_BADVADDR_EN
    // BadVAddr: captured only on address-error exceptions (codes 4 and 5).
    always_ff @(posedge iCLK) begin
        if (iCLR)
            badVAddr_r <= 32'd0;
        else if (excAct_s && ((bus.iExcCode == 5'd4) || (bus.iExcCode == 5'd5)))
            badVAddr_r <= bus.iBadVAddr;
    end
`endif

    // Read mux: eret target overrides the mfc0 path.
    always_comb begin
        cmpRead_s = 32'd0;
        for (int k = 0; k < NUM_CMP; k++) begin
            cmpRead_s = cmpRead_s |
                        (compare_r[k] & {32{bus.iReadRegister == cmpAddr(k)}});
        end
        causeRead_s = {causeBd_r, 15'd0, |tp_r, bus.iPendingInterrupt[6:2],
                       bus.iPendingInterrupt[1:0] | swInt_r, 1'b0, excCode_r, 2'b00};
        if (bus.iEret) begin
            readData_s = causeBd_r ? epc_r : (epc_r + 32'd4);
        end else begin
            case (bus.iReadRegister)
`ifdef COP0_BADVADDR_EN
                5'd8:    readData_s = badVAddr_r;
`endif
                5'd9:    readData_s = count_r;
                5'd12:   readData_s = sr_r;
                5'd13:   readData_s = causeRead_s;
                5'd14:   readData_s = epc_r;
                default: readData_s = cmpRead_s;
            endcase
        end
        mask_s = sr_r[0] ? (sr_r[15:8] & causeRead_s[15:8]) : 8'd0;
    end

    assign bus.oReadData      = readData_s;
    assign bus.oInterruptMask = mask_s;
    assign bus.oIrq           = (|mask_s) & ~sr_r[1];
    assign bus.oUserMode      = sr_r[4];
    assign bus.oExcLevel      = sr_r[1];
    assign bus.oTimerPending  = tp_r;
endmodule
